// File: rtl/id_ex_stage_pkg.sv
// Shared constants for the ID/EX stage: datapath widths, opcode encodings and
// the operand-usage helpers used by load-use hazard detection.
package id_ex_stage_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 4;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_RED    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;
    localparam logic [3:0] OP_LW     = 4'b1000;
    localparam logic [3:0] OP_SW     = 4'b1001;
    localparam logic [3:0] OP_LLB    = 4'b1010;
    localparam logic [3:0] OP_LHB    = 4'b1011;
    localparam logic [3:0] OP_B      = 4'b1100;
    localparam logic [3:0] OP_BR     = 4'b1101;
    localparam logic [3:0] OP_PCS    = 4'b1110;
    localparam logic [3:0] OP_HLT    = 4'b1111;

    // RED sets no flags and touches neither memory nor the PC, so it is a safe bubble.
    localparam logic [3:0] OP_BUBBLE = OP_RED;

    function automatic logic uses_rs(input logic [3:0] op);
        return !(op == OP_B || op == OP_PCS || op == OP_HLT);
    endfunction

    function automatic logic uses_rt(input logic [3:0] op);
        return (op == OP_ADD || op == OP_SUB || op == OP_XOR || op == OP_RED ||
                op == OP_PADDSB || op == OP_SW);
    endfunction

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select: R0 is zero, EX/MEM beats MEM/WB, else register-file data.
module fwd_mux #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) (
    input  logic [REG_AW-1:0] addr,
    input  logic [REG_AW-1:0] exm_rd_addr,
    input  logic              exm_reg_wen,
    input  logic [DATA_W-1:0] exm_result,
    input  logic [REG_AW-1:0] mwb_rd_addr,
    input  logic              mwb_reg_wen,
    input  logic [DATA_W-1:0] mwb_result,
    input  logic [DATA_W-1:0] reg_data,
    output logic [DATA_W-1:0] value
);

    always_comb begin
        value = reg_data;
        if (addr == '0)
            value = '0;
        else if (exm_reg_wen && exm_rd_addr == addr)
            value = exm_result;
        else if (mwb_reg_wen && mwb_rd_addr == addr)
            value = mwb_result;
    end

endmodule

// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register feeding the ALU, with operand forwarding,
// immediate selection, stall/flush control and load-use hazard detection.
module id_ex_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [3:0]        id_opcode,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [7:0]        id_imm,
    input  logic              id_reg_wen,
    input  logic [REG_AW-1:0] exm_rd_addr,
    input  logic              exm_reg_wen,
    input  logic [DATA_W-1:0] exm_result,
    input  logic [REG_AW-1:0] mwb_rd_addr,
    input  logic              mwb_reg_wen,
    input  logic [DATA_W-1:0] mwb_result,
    output logic              ex_valid,
    output logic [3:0]        ex_opcode,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic              ex_reg_wen,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [DATA_W-1:0] ex_store_data,
    output logic              load_use_stall
);
    import id_ex_stage_pkg::*;

    logic              valid_q;
    logic [3:0]        opcode_q;
    logic [REG_AW-1:0] rd_q;
    logic              wen_q;
    logic [REG_AW-1:0] rs_addr_q;
    logic [REG_AW-1:0] rt_addr_q;
    logic [DATA_W-1:0] rs_data_q;
    logic [DATA_W-1:0] rt_data_q;
    logic [7:0]        imm_q;
    logic [DATA_W-1:0] rs_fwd;
    logic [DATA_W-1:0] rt_fwd;

    // Flush outranks stall so a squashed instruction never lingers in EX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            opcode_q  <= OP_BUBBLE;
            rd_q      <= '0;
            wen_q     <= 1'b0;
            rs_addr_q <= '0;
            rt_addr_q <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
        end else if (flush) begin
            valid_q   <= 1'b0;
            opcode_q  <= OP_BUBBLE;
            rd_q      <= '0;
            wen_q     <= 1'b0;
            rs_addr_q <= '0;
            rt_addr_q <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
        end else if (!stall) begin
            valid_q   <= id_valid;
            opcode_q  <= id_opcode;
            rd_q      <= id_rd_addr;
            wen_q     <= id_reg_wen;
            rs_addr_q <= id_rs_addr;
            rt_addr_q <= id_rt_addr;
            rs_data_q <= id_rs_data;
            rt_data_q <= id_rt_data;
            imm_q     <= id_imm;
        end
    end

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rs (
        .addr(rs_addr_q), .exm_rd_addr(exm_rd_addr), .exm_reg_wen(exm_reg_wen),
        .exm_result(exm_result), .mwb_rd_addr(mwb_rd_addr), .mwb_reg_wen(mwb_reg_wen),
        .mwb_result(mwb_result), .reg_data(rs_data_q), .value(rs_fwd)
    );

    fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd_rt (
        .addr(rt_addr_q), .exm_rd_addr(exm_rd_addr), .exm_reg_wen(exm_reg_wen),
        .exm_result(exm_result), .mwb_rd_addr(mwb_rd_addr), .mwb_reg_wen(mwb_reg_wen),
        .mwb_result(mwb_result), .reg_data(rt_data_q), .value(rt_fwd)
    );

    always_comb begin
        alu_in2 = '0;
        case (opcode_q)
            OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB:
                alu_in2 = rt_fwd;
            OP_SLL, OP_SRA, OP_ROR:
                alu_in2 = {{(DATA_W-4){1'b0}}, imm_q[3:0]};
            OP_LW, OP_SW:
                alu_in2 = {{(DATA_W-4){imm_q[3]}}, imm_q[3:0]};
            OP_LLB, OP_LHB:
                alu_in2 = {{(DATA_W-8){1'b0}}, imm_q};
            default:
                alu_in2 = '0;
        endcase
    end

    assign ex_valid      = valid_q;
    assign ex_opcode     = opcode_q;
    assign ex_rd_addr    = rd_q;
    assign ex_reg_wen    = wen_q & valid_q;
    assign alu_in1       = rs_fwd;
    assign ex_store_data = rt_fwd;

    // A load in EX cannot forward its data yet, so a dependent ID instruction must wait.
    assign load_use_stall = valid_q && (opcode_q == OP_LW) && (rd_q != '0) && id_valid &&
                            ((uses_rs(id_opcode) && id_rs_addr == rd_q) ||
                             (uses_rt(id_opcode) && id_rt_addr == rd_q));

endmodule
